spi_flash_responder: RTL and testbench
======================================

Name: spi_flash_responder

Overview:
- Byte-lane SPI NOR flash responder: the device end of the byte-wide SPI link that the APB-to-SPI controller drives.
- Decodes the opcode, the 24-bit address and the data phase. Serves reads from an internal byte array and applies NOR-style programming to it.
- Used as the flash model in the controller testbench and as a synthesizable on-chip flash emulator.
- One SPI byte is transferred per s_clk rising edge while s_css is low.

Parameters:
- ADDR_BITS, 8, implemented address bits; array depth = 2**ADDR_BITS bytes; upper address bits are ignored.
- PAGE_BITS, 4, page size = 2**PAGE_BITS bytes; page-program wrap boundary.

Ports:
- s_clk  input  1  SPI byte clock; the only clock.
- s_rst  input  1  asynchronous active-high reset.
- s_css  input  1  chip select, active low.
- s_mosi  input  8  command/address/data byte from the controller.
- s_miso  output  8  registered response byte to the controller.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high (s_clk, s_rst).
- Reset values:
  - s_miso = 8'h00; FSM = CMD; byte counter = 0; WEL = 0.
  - Every array byte = 8'hFF.
- A byte is accepted on posedge s_clk when s_css = 0. Bytes are numbered 0..n within one select window.
- Byte 0 is the opcode. Bytes 1-3 are address MSB..LSB. Only the low ADDR_BITS of the 24-bit address are kept.
- States and transitions:
  - CMD: next state is chosen by the opcode (rows below).
  - ADDR: counts three bytes, then goes to RD or PROG.
  - RD: streams data.
  - PROG: applies data bytes to the array.
  - STAT: returns the status byte.
  - IGNORE: holds until s_css goes high.
- Opcodes:
  - 8'h03 READ: CMD -> ADDR. On the edge that accepts address byte 3, s_miso <= mem[a]. On each later edge, a <= a+1 and s_miso <= mem[a+1]. The address wraps modulo 2**ADDR_BITS. Read latency: data is valid for the byte slot immediately after the last address byte.
  - 8'h02 PAGE PROGRAM: CMD -> ADDR -> PROG. Each data byte d does mem[a] <= mem[a] & d, so bits only change 1->0. The address increments and wraps inside the page: the upper bits are fixed and the low PAGE_BITS wrap. The array is written only if WEL = 1. With WEL = 0, the bytes are consumed and the array is unchanged.
  - 8'h06 WREN: sets WEL on the opcode edge, then IGNORE.
  - 8'h04 WRDI: clears WEL, then IGNORE.
  - 8'h05 RDSR: on the opcode edge s_miso <= {6'b0, WEL, 1'b0}. It repeats on every later edge while selected.
  - Any other opcode: IGNORE, with s_miso = 8'h00.
- s_css high on a posedge s_clk:
  - FSM goes to CMD, byte counter clears, s_miso <= 8'h00.
  - If the window that just ended was a PAGE PROGRAM that reached PROG, WEL clears.
  - WREN/WRDI take effect regardless of window length.
- A window that ends during ADDR aborts with no array change. WEL is kept.
- s_rst asserted mid-transfer returns everything to reset values immediately. This includes re-initialising the array to 8'hFF.
- s_miso changes only on posedge s_clk.
- In ADDR, PROG and IGNORE, s_miso = 8'h00.

Optional Feature:
- Macro: SPI_FLASH_RESP_ERASE_EN.
- Defined: opcode 8'h20 SECTOR ERASE (opcode plus 3 address bytes) is accepted, with the sector = the page containing the address.
  - On the edge accepting address byte 3, if WEL = 1, every byte of that page becomes 8'hFF and WEL clears.
  - If WEL = 0, the command is a no-op.
  - The FSM then goes to IGNORE.
- Undefined: 8'h20 is treated as an unknown opcode (IGNORE). No erase logic is built.

Decomposition:
- Shared package spi_flash_pkg holds:
  - opcode constants OP_READ, OP_PP, OP_WREN, OP_WRDI, OP_RDSR, OP_SE;
  - the FSM state encoding;
  - status bit positions SR_WIP = 0, SR_WEL = 1.
  The controller uses the same opcode constants.
- Sub-module spi_flash_array: byte array with a one-port read, an AND-write and an optional page-clear. It holds the reset fill and the wrap arithmetic.

Test Plan:
- After reset, select and send 03,00,00,10 then 4 dummy bytes -> s_miso = FF,FF,FF,FF in byte slots 4-7, and 00 before them.
- Send 06 and deselect. Send 02,00,00,20,A5,3C,F0,0F and deselect. Read 03,00,00,20 plus 4 bytes -> A5,3C,F0,0F. A following RDSR returns 8'h00 (WEL cleared).
- Without WREN, send 02,00,00,40,00 -> a read of 0x40 returns FF. A second program of 0F over F0 with WEL = 1 -> reads 00 (AND semantics).
- Send 06 and deselect. Send 02,00,00,1E,11,22,33 -> bytes 0x1E = 11, 0x1F = 22, 0x10 = 33 (page wrap). A read from 0xFF with 2 data bytes returns mem[FF], mem[00] (array wrap).
- Send 06 then 05 with 3 extra clocks -> s_miso = 02,02,02,02. Opcode 9F -> s_miso stays 00. Assert s_rst mid-READ -> s_miso = 00 at once and the array reads FF.
- With SPI_FLASH_RESP_ERASE_EN: program 0x23 = 00, then 06; 20,00,00,25 -> the whole page 0x20-0x2F reads FF and WEL = 0. Without the macro, the same sequence leaves 0x23 = 00.

Source files
------------

// File: rtl/spi_flash_pkg.sv
// Shared constants for the byte-lane SPI NOR flash link: opcodes, responder FSM encoding
// and status-register bit positions.
package spi_flash_pkg;

  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [7:0] OP_PP   = 8'h02;
  localparam logic [7:0] OP_WREN = 8'h06;
  localparam logic [7:0] OP_WRDI = 8'h04;
  localparam logic [7:0] OP_RDSR = 8'h05;
  localparam logic [7:0] OP_SE   = 8'h20;

  localparam logic [2:0] StCmd    = 3'd0;
  localparam logic [2:0] StAddr   = 3'd1;
  localparam logic [2:0] StRd     = 3'd2;
  localparam logic [2:0] StProg   = 3'd3;
  localparam logic [2:0] StStat   = 3'd4;
  localparam logic [2:0] StIgnore = 3'd5;

  localparam int unsigned SR_WIP = 0;
  localparam int unsigned SR_WEL = 1;

  function automatic logic [7:0] status_byte(input logic wel);
    logic [7:0] sr;
    sr         = 8'h00;
    sr[SR_WEL] = wel;
    return sr;
  endfunction

endpackage

// File: rtl/spi_flash_array.sv
// Flash byte array: combinational read, NOR-style AND write, optional whole-page clear,
// plus the linear and in-page pointer increment used by read and program streams.
module spi_flash_array #(
  parameter int unsigned ADDR_BITS = 8,
  parameter int unsigned PAGE_BITS = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [ADDR_BITS-1:0] rd_addr_i,
  output logic [7:0]           rd_data_o,
  input  logic [ADDR_BITS-1:0] ptr_i,
  output logic [ADDR_BITS-1:0] ptr_inc_o,
  output logic [ADDR_BITS-1:0] ptr_page_inc_o,
  input  logic                 wr_en_i,
  input  logic [7:0]           wr_data_i,
  input  logic                 clr_en_i,
  input  logic [ADDR_BITS-1:0] clr_addr_i
);

  localparam int unsigned Depth = 2 ** ADDR_BITS;
  localparam logic [ADDR_BITS-1:0] PageMask = ADDR_BITS'((1 << PAGE_BITS) - 1);

  logic [7:0] mem_q [Depth];

  assign rd_data_o      = mem_q[rd_addr_i];
  assign ptr_inc_o      = ptr_i + ADDR_BITS'(1);
  // Page-program pointer: upper bits pinned, low PAGE_BITS wrap.
  assign ptr_page_inc_o = (ptr_i & ~PageMask) | (ptr_inc_o & PageMask);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= 8'hFF;
      end
    end else begin
      if (wr_en_i) begin
        mem_q[ptr_i] <= mem_q[ptr_i] & wr_data_i;
      end
      if (clr_en_i) begin
        for (int i = 0; i < Depth; i++) begin
          if ((ADDR_BITS'(i) >> PAGE_BITS) == (clr_addr_i >> PAGE_BITS)) begin
            mem_q[i] <= 8'hFF;
          end
        end
      end
    end
  end

endmodule

// File: rtl/spi_flash_responder.sv
// Byte-lane SPI NOR flash responder: opcode/address/data decode over a byte-wide link.
// Define SPI_FLASH_RESP_ERASE_EN to add the 8'h20 sector (page) erase command.
module spi_flash_responder
  import spi_flash_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 8,
  parameter int unsigned PAGE_BITS = 4
) (
  input  logic       s_clk,
  input  logic       s_rst,
  input  logic       s_css,
  input  logic [7:0] s_mosi,
  output logic [7:0] s_miso
);

  logic [2:0]           state_q, state_d;
  logic [1:0]           cnt_q, cnt_d;
  logic [7:0]           op_q, op_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic                 wel_q, wel_d;
  logic [7:0]           miso_q, miso_d;

  logic [ADDR_BITS-1:0] addr_asm, rd_addr, ptr_inc, ptr_page_inc;
  logic [7:0]           rd_data;
  logic                 wr_en, clr_en;

  // Address bytes arrive MSB first; bits above ADDR_BITS fall off the top.
  assign addr_asm = (addr_q << 8) | ADDR_BITS'(s_mosi);
  assign rd_addr  = (state_q == StAddr) ? addr_asm : ptr_inc;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wel_d   = wel_q;
    miso_d  = 8'h00;
    wr_en   = 1'b0;
    clr_en  = 1'b0;
    if (s_css) begin
      state_d = StCmd;
      cnt_d   = 2'd0;
      if (state_q == StProg) wel_d = 1'b0;
    end else begin
      case (state_q)
        StCmd: begin
          case (s_mosi)
            OP_READ, OP_PP: begin
              state_d = StAddr;
              op_d    = s_mosi;
            end
`ifdef SPI_FLASH_RESP_ERASE_EN
            OP_SE: begin
              state_d = StAddr;
              op_d    = s_mosi;
            end
`endif
            OP_WREN: begin
              wel_d   = 1'b1;
              state_d = StIgnore;
            end
            OP_WRDI: begin
              wel_d   = 1'b0;
              state_d = StIgnore;
            end
            OP_RDSR: begin
              state_d = StStat;
              miso_d  = status_byte(wel_q);
            end
            default: state_d = StIgnore;
          endcase
        end
        StAddr: begin
          addr_d = addr_asm;
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd2) begin
            cnt_d = 2'd0;
            case (op_q)
              OP_READ: begin
                state_d = StRd;
                miso_d  = rd_data;
              end
`ifdef SPI_FLASH_RESP_ERASE_EN
              OP_SE: begin
                if (wel_q) begin
                  clr_en = 1'b1;
                  wel_d  = 1'b0;
                end
                state_d = StIgnore;
              end
`endif
              default: state_d = StProg;
            endcase
          end
        end
        StRd: begin
          addr_d = ptr_inc;
          miso_d = rd_data;
        end
        StProg: begin
          wr_en  = wel_q;
          addr_d = ptr_page_inc;
        end
        StStat:  miso_d = status_byte(wel_q);
        default: ;
      endcase
    end
  end

  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      state_q <= StCmd;
      cnt_q   <= 2'd0;
      op_q    <= 8'h00;
      addr_q  <= '0;
      wel_q   <= 1'b0;
      miso_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wel_q   <= wel_d;
      miso_q  <= miso_d;
    end
  end

  assign s_miso = miso_q;

  spi_flash_array #(
    .ADDR_BITS(ADDR_BITS),
    .PAGE_BITS(PAGE_BITS)
  ) u_array (
    .clk_i         (s_clk),
    .rst_i         (s_rst),
    .rd_addr_i     (rd_addr),
    .rd_data_o     (rd_data),
    .ptr_i         (addr_q),
    .ptr_inc_o     (ptr_inc),
    .ptr_page_inc_o(ptr_page_inc),
    .wr_en_i       (wr_en),
    .wr_data_i     (s_mosi),
    .clr_en_i      (clr_en),
    .clr_addr_i    (addr_asm)
  );

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: full-duplex byte exchanges, each slot's s_miso
// sampled on the falling edge before the byte it accompanies is clocked in.
module tb_spi_flash_responder;

  logic       s_clk = 1'b0;
  logic       s_rst;
  logic       s_css;
  logic [7:0] s_mosi;
  logic [7:0] s_miso;

  int n_pass  = 0;
  int n_total = 0;
  logic [7:0] g;
  logic [7:0] rb [16];

`ifdef SPI_FLASH_RESP_ERASE_EN
  localparam logic [7:0] ExpP20 = 8'hFF;
  localparam logic [7:0] ExpP21 = 8'hFF;
  localparam logic [7:0] ExpP23 = 8'hFF;
  localparam logic [7:0] ExpSrSe = 8'h00;
`else
  localparam logic [7:0] ExpP20 = 8'hA5;
  localparam logic [7:0] ExpP21 = 8'h3C;
  localparam logic [7:0] ExpP23 = 8'h00;
  localparam logic [7:0] ExpSrSe = 8'h02;
`endif

  spi_flash_responder #(
    .ADDR_BITS(8),
    .PAGE_BITS(4)
  ) dut (
    .s_clk (s_clk),
    .s_rst (s_rst),
    .s_css (s_css),
    .s_mosi(s_mosi),
    .s_miso(s_miso)
  );

  always #5 s_clk = ~s_clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %02h expected %02h", tag, got, exp);
  endtask

  task automatic xfer(input logic [7:0] b, output logic [7:0] got);
    @(negedge s_clk);
    got    = s_miso;
    s_css  = 1'b0;
    s_mosi = b;
    @(posedge s_clk);
  endtask

  task automatic desel(output logic [7:0] got);
    @(negedge s_clk);
    got    = s_miso;
    s_css  = 1'b1;
    s_mosi = 8'h00;
    @(posedge s_clk);
  endtask

  task automatic cmd1(input logic [7:0] op);
    logic [7:0] d;
    xfer(op, d);
    desel(d);
  endtask

  task automatic rd(input logic [7:0] a, input int n);
    logic [7:0] d;
    xfer(8'h03, d);
    xfer(8'h00, d);
    xfer(8'h00, d);
    xfer(a, d);
    for (int i = 0; i < n; i++) begin
      xfer(8'h00, d);
      rb[i] = d;
    end
    desel(d);
  endtask

  task automatic pp(input logic [7:0] a, input logic [7:0] d0, input logic [7:0] d1,
                    input logic [7:0] d2, input logic [7:0] d3, input int n);
    logic [7:0] d;
    logic [7:0] v [4];
    v = '{d0, d1, d2, d3};
    xfer(8'h02, d);
    xfer(8'h00, d);
    xfer(8'h00, d);
    xfer(a, d);
    for (int i = 0; i < n; i++) xfer(v[i], d);
    desel(d);
  endtask

  initial begin
    s_rst  = 1'b1;
    s_css  = 1'b1;
    s_mosi = 8'h00;
    repeat (2) @(posedge s_clk);
    @(negedge s_clk);
    s_rst = 1'b0;
    check("reset_miso", s_miso, 8'h00);

    // Read of erased array: zeros through the address phase, then FF.
    xfer(8'h03, g);
    xfer(8'h00, g);
    xfer(8'h00, g);
    xfer(8'h10, g);
    check("rd_slot3", g, 8'h00);
    for (int i = 0; i < 4; i++) begin
      xfer(8'h00, g);
      check("rd_erased", g, 8'hFF);
    end
    desel(g);

    // Enabled page program, read back, WEL cleared by the program.
    cmd1(8'h06);
    pp(8'h20, 8'hA5, 8'h3C, 8'hF0, 8'h0F, 4);
    rd(8'h20, 4);
    check("pp_b0", rb[0], 8'hA5);
    check("pp_b1", rb[1], 8'h3C);
    check("pp_b2", rb[2], 8'hF0);
    check("pp_b3", rb[3], 8'h0F);
    xfer(8'h05, g);
    desel(g);
    check("sr_after_pp", g, 8'h00);

    // Program without WEL is ignored; AND semantics with WEL.
    pp(8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 1);
    rd(8'h40, 1);
    check("pp_no_wel", rb[0], 8'hFF);
    cmd1(8'h06);
    pp(8'h40, 8'hF0, 8'h00, 8'h00, 8'h00, 1);
    rd(8'h40, 1);
    check("pp_f0", rb[0], 8'hF0);
    cmd1(8'h06);
    pp(8'h40, 8'h0F, 8'h00, 8'h00, 8'h00, 1);
    rd(8'h40, 1);
    check("pp_and", rb[0], 8'h00);

    // Page wrap on program, array wrap on read.
    cmd1(8'h06);
    pp(8'h1E, 8'h11, 8'h22, 8'h33, 8'h00, 3);
    rd(8'h1E, 2);
    check("pw_1e", rb[0], 8'h11);
    check("pw_1f", rb[1], 8'h22);
    rd(8'h10, 1);
    check("pw_10", rb[0], 8'h33);
    cmd1(8'h06);
    pp(8'hFF, 8'h5A, 8'h00, 8'h00, 8'h00, 1);
    cmd1(8'h06);
    pp(8'h00, 8'hC3, 8'h00, 8'h00, 8'h00, 1);
    rd(8'hFF, 2);
    check("aw_ff", rb[0], 8'h5A);
    check("aw_00", rb[1], 8'hC3);

    // Status repeats while selected.
    cmd1(8'h06);
    xfer(8'h05, g);
    check("rdsr_slot0", g, 8'h00);
    for (int i = 0; i < 3; i++) begin
      xfer(8'h00, g);
      check("rdsr_rep", g, 8'h02);
    end
    desel(g);
    check("rdsr_last", g, 8'h02);
    cmd1(8'h04);
    xfer(8'h05, g);
    desel(g);
    check("sr_wrdi", g, 8'h00);

    // Unknown opcode keeps s_miso at zero.
    xfer(8'h9F, g);
    xfer(8'h00, g);
    check("unk_1", g, 8'h00);
    xfer(8'h00, g);
    check("unk_2", g, 8'h00);
    desel(g);

    // Window aborted in the address phase keeps WEL and leaves the array alone.
    cmd1(8'h06);
    xfer(8'h02, g);
    xfer(8'h00, g);
    xfer(8'h00, g);
    desel(g);
    xfer(8'h05, g);
    desel(g);
    check("sr_abort", g, 8'h02);
    rd(8'h00, 1);
    check("abort_mem", rb[0], 8'hC3);

    // Sector erase (page of 0x25) or, without the feature, an ignored opcode.
    cmd1(8'h06);
    pp(8'h23, 8'h00, 8'h00, 8'h00, 8'h00, 1);
    cmd1(8'h06);
    xfer(8'h20, g);
    xfer(8'h00, g);
    xfer(8'h00, g);
    xfer(8'h25, g);
    desel(g);
    rd(8'h20, 16);
    check("se_20", rb[0], ExpP20);
    check("se_23", rb[3], ExpP23);
    check("se_2f", rb[15], 8'hFF);
    xfer(8'h05, g);
    desel(g);
    check("sr_se", g, ExpSrSe);

    // Asynchronous reset in the middle of a read stream.
    xfer(8'h03, g);
    xfer(8'h00, g);
    xfer(8'h00, g);
    xfer(8'h20, g);
    xfer(8'h00, g);
    check("pre_rst", g, ExpP20);
    #2 s_rst = 1'b1;
    #1 check("rst_miso", s_miso, 8'h00);
    @(negedge s_clk);
    s_rst = 1'b0;
    s_css = 1'b1;
    rd(8'h20, 1);
    check("rst_20", rb[0], 8'hFF);
    rd(8'h40, 1);
    check("rst_40", rb[0], 8'hFF);
    xfer(8'h05, g);
    desel(g);
    check("rst_sr", g, 8'h00);
    check("pre_rst_21_ref", ExpP21 & 8'h00, 8'h00 & rb[0]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
